imm_decode_stage: RTL and testbench
===================================

Name: imm_decode_stage

Overview:
- Registered, parametrised immediate-generation stage between the fetch buffer and register-read in the RV32I/RV64I core.
- Decodes the format and sign/zero-extended immediate of every base-ISA format plus the Zicsr zimm field.
- Passes PC and instruction through alongside the immediate.
- Decouples both sides with a valid/ready handshake and a 2-entry skid buffer, so in_ready is a registered signal.

Parameters:
XLEN, 32, datapath width of imm and pc; legal values 32 or 64.
EN_ZICSR, 1, 1 = decode zimm for CSR*I instructions; 0 = treat SYSTEM opcode as format NONE.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
flush  input  1  discard all buffered entries (branch redirect).
in_valid  input  1  upstream instruction valid.
in_ready  output  1  stage can accept; registered.
in_instr  input  32  raw instruction word.
in_pc  input  XLEN  PC of in_instr.
out_valid  output  1  output entry valid.
out_ready  input  1  downstream accepts.
out_instr  output  32  instruction passthrough.
out_pc  output  XLEN  PC passthrough.
out_imm  output  XLEN  decoded immediate.
out_fmt  output  3  0 NONE(R), 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z(zimm).
out_illegal  output  1  opcode not recognised, or instr[1:0] != 2'b11.

Behaviour:
- Opcode is instr[6:0].
- Decode is combinational on in_instr; the result is captured on acceptance.
- Immediate rules; "sext" means sign-extend from instr[31] to XLEN:
  - I (0010011, 0000011, 1100111): sext(instr[31:20]).
  - S (0100011): sext({instr[31:25], instr[11:7]}).
  - B (1100011): sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U (0110111, 0010111): sext({instr[31:12], 12'b0}); for XLEN=64, bits 63:32 are copies of instr[31].
  - J (1101111): sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - Z: opcode 1110011 with funct3[2]=1 and EN_ZICSR=1 gives zero-extended instr[19:15]. Any other 1110011 gives fmt NONE, imm 0, not illegal.
  - R (0110011), FENCE (0001111): fmt NONE, imm 0.
  - Any other opcode, or instr[1:0] != 2'b11: fmt NONE, imm 0, illegal 1.
- Handshake:
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - Inputs are held while in_valid=1 and in_ready=0.
  - out_* hold stable while out_valid=1 and out_ready=0.
- Latency: an instruction accepted at edge N is presented at out_* after edge N; minimum 1 cycle.
- Throughput: 1 per cycle when out_ready stays high.
- State machine (main register M, skid register K):
  - EMPTY: in accept -> ONE.
  - ONE: accept and no drain -> TWO (entry goes to K). Drain and no accept -> EMPTY. Both -> ONE (M reloads).
  - TWO: drain -> ONE (K moves to M). An input accept is impossible because in_ready=0.
  - in_ready is registered: 1 in EMPTY/ONE, 0 in TWO.
- Order is strictly FIFO; no entry is dropped or duplicated.
- Flush:
  - Next state is EMPTY, out_valid=0 next cycle, in_ready=1 next cycle.
  - An input presented in the flush cycle is not accepted, even if in_ready=1.
  - Flush overrides simultaneous accept and drain; a drain in the flush cycle still counts as consumed downstream.
- Reset (rst=1 at an edge, including mid-stream):
  - State EMPTY, out_valid=0, in_ready=1.
  - out_instr=32'h00000013 (NOP), out_pc=0, out_imm=0, out_fmt=0, out_illegal=0.
  - rst has priority over flush.
- Data registers update only on accept or shift, to save power.

Test Plan:
- XLEN=32, in 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> after one edge: out_imm=0xFFFFFFFF, fmt=1, illegal=0; in_ready stays 1.
- Back-to-back 0xFE112E23 (sw) then 0xFF9FF06F (jal -8) -> consecutive outputs: imm 0xFFFFFFFC fmt 2, then 0xFFFFFFF8 fmt 5.
- XLEN=64: 0x123452B7 -> imm 0x0000000012345000 fmt 4. Then 0x800002B7 -> imm 0xFFFFFFFF80000000. Then 0x0002D073 (csrrwi, zimm=5) -> imm 5 fmt 6. Then 0x00000000 -> illegal=1 fmt 0.
- Backpressure: out_ready=0, offer A, B, C every cycle -> A and B accepted, in_ready=0 after 2nd accept, C held. out_ready=1 -> outputs A, B, C in order, no gaps beyond one cycle.
- Buffer in TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, input not captured. Next offered instruction appears alone.
- rst asserted while in TWO with out_ready=0 -> next cycle out_valid=0, in_ready=1, out_instr=0x00000013; prior entries never appear.

Source files
------------

// File: rtl/imm_decode_stage.sv
// imm_decode_stage
// Immediate-generation stage between the fetch buffer and register-read.
// Each instruction is decoded combinationally on entry, and the decoded
// format, immediate and illegal flag are captured together with its PC and
// instruction word. A two-entry buffer (main M, skid K) decouples the sides.
// in_ready is driven from a flop, so the upstream path never sees
// combinational logic from out_ready.

module imm_decode_stage #(
  parameter int XLEN     = 32,
  parameter bit EN_ZICSR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  // Format codes presented on out_fmt
  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  // Base-ISA major opcodes
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  // Value held in the output registers after reset: addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // One buffered, fully decoded instruction
  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  localparam entry_t ENTRY_RESET = '{
    instr:   NOP_INSTR,
    pc:      '0,
    imm:     '0,
    fmt:     FMT_NONE,
    illegal: 1'b0
  };

  state_t state_q, state_d;
  entry_t m_q, m_d;          // main register, drives out_*
  entry_t k_q, k_d;          // skid register, second entry
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;
  entry_t          dec_entry;

  logic accept;
  logic drain;

  // Flush blocks acceptance even while in_ready is high
  assign accept = in_valid && in_ready_q && !flush;
  assign drain  = out_valid_q && out_ready;

  // Decode the incoming word: format, sign/zero-extended immediate, legality.
  // The replication counts fold the sign bit into the extension so the
  // expressions stay valid for both XLEN=32 and XLEN=64.
  always_comb begin
    dec_imm     = '0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    if (in_instr[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
    end else begin
      case (in_instr[6:0])
        OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
          dec_fmt = FMT_I;
          dec_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        end
        OPC_STORE: begin
          dec_fmt = FMT_S;
          dec_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        end
        OPC_BRANCH: begin
          dec_fmt = FMT_B;
          dec_imm = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
        end
        OPC_LUI, OPC_AUIPC: begin
          dec_fmt = FMT_U;
          dec_imm = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
        end
        OPC_JAL: begin
          dec_fmt = FMT_J;
          dec_imm = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
        end
        OPC_SYSTEM: begin
          // Only the CSR*I forms (funct3[2]=1) carry a zimm; ECALL/EBREAK and
          // register-source CSR ops are legal with no immediate.
          if (EN_ZICSR && in_instr[14]) begin
            dec_fmt = FMT_Z;
            dec_imm = {{(XLEN-5){1'b0}}, in_instr[19:15]};
          end
        end
        OPC_OP, OPC_FENCE: begin
          dec_fmt = FMT_NONE;
        end
        default: begin
          dec_illegal = 1'b1;
        end
      endcase
    end
  end

  assign dec_entry = '{
    instr:   in_instr,
    pc:      in_pc,
    imm:     dec_imm,
    fmt:     dec_fmt,
    illegal: dec_illegal
  };

  // Buffer control: next state plus enables for the M and K data registers.
  // Data registers only change on a load or a K->M shift.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    k_d     = k_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            m_d     = dec_entry;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            m_d = dec_entry;
          end else if (accept) begin
            state_d = ST_TWO;
            k_d     = dec_entry;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a drain can happen
          if (drain) begin
            state_d = ST_ONE;
            m_d     = k_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // State and data registers; reset takes priority over flush
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      m_q         <= ENTRY_RESET;
      k_q         <= ENTRY_RESET;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      m_q         <= m_d;
      k_q         <= k_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_instr   = m_q.instr;
  assign out_pc      = m_q.pc;
  assign out_imm     = m_q.imm;
  assign out_fmt     = m_q.fmt;
  assign out_illegal = m_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed testbench for imm_decode_stage: one XLEN=32 and one XLEN=64
// instance, hand-computed expected values, immediate assertions.

module tb_imm_decode_stage;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // XLEN=32 instance
  logic        flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [31:0] in_instr_a, in_pc_a, out_instr_a, out_pc_a, out_imm_a;
  logic [2:0]  out_fmt_a;
  logic        out_illegal_a;

  // XLEN=64 instance
  logic        flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [31:0] in_instr_b, out_instr_b;
  logic [63:0] in_pc_b, out_pc_b, out_imm_b;
  logic [2:0]  out_fmt_b;
  logic        out_illegal_b;

  imm_decode_stage #(.XLEN(32), .EN_ZICSR(1'b1)) u_a (
    .clk(clk), .rst(rst), .flush(flush_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_instr(in_instr_a), .in_pc(in_pc_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_instr(out_instr_a), .out_pc(out_pc_a), .out_imm(out_imm_a),
    .out_fmt(out_fmt_a), .out_illegal(out_illegal_a)
  );

  imm_decode_stage #(.XLEN(64), .EN_ZICSR(1'b1)) u_b (
    .clk(clk), .rst(rst), .flush(flush_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_instr(in_instr_b), .in_pc(in_pc_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_instr(out_instr_b), .out_pc(out_pc_b), .out_imm(out_imm_b),
    .out_fmt(out_fmt_b), .out_illegal(out_illegal_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled off the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer_a(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid_a = v;
    in_instr_a = instr;
    in_pc_a    = pc;
  endtask

  task automatic step_b(input logic [31:0] instr, input logic [63:0] pc);
    in_valid_b = 1'b1;
    in_instr_b = instr;
    in_pc_b    = pc;
    tick();
    $display("b: instr=%h pc=%h -> valid=%b imm=%h fmt=%0d ill=%b",
             instr, pc, out_valid_b, out_imm_b, out_fmt_b, out_illegal_b);
  endtask

  initial begin
    rst = 1'b1;
    flush_a = 1'b0; out_ready_a = 1'b1; offer_a(1'b0, 32'h0, 32'h0);
    flush_b = 1'b0; out_ready_b = 1'b1; in_valid_b = 1'b0;
    in_instr_b = 32'h0; in_pc_b = 64'h0;
    tick();
    tick();

    // ---- reset state ----
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_out_instr", out_instr_a, 32'h0000_0013);
    chk("rst_out_pc", out_pc_a, 0);
    chk("rst_out_imm", out_imm_a, 0);
    chk("rst_out_fmt", out_fmt_a, 0);
    chk("rst_out_illegal", out_illegal_a, 0);
    chk("rst_b_out_valid", out_valid_b, 0);
    rst = 1'b0;

    // ---- addi x1,x0,-1 : latency one edge ----
    offer_a(1'b1, 32'hFFF0_0093, 32'h100);
    tick();
    $display("a: addi -> valid=%b imm=%h fmt=%0d", out_valid_a, out_imm_a, out_fmt_a);
    chk("addi_valid", out_valid_a, 1);
    chk("addi_imm", out_imm_a, 32'hFFFF_FFFF);
    chk("addi_fmt", out_fmt_a, 1);
    chk("addi_ill", out_illegal_a, 0);
    chk("addi_pc", out_pc_a, 32'h100);
    chk("addi_in_ready", in_ready_a, 1);

    // ---- back-to-back sw then jal ----
    offer_a(1'b1, 32'hFE11_2E23, 32'h104);
    tick();
    $display("a: sw -> imm=%h fmt=%0d", out_imm_a, out_fmt_a);
    chk("sw_imm", out_imm_a, 32'hFFFF_FFFC);
    chk("sw_fmt", out_fmt_a, 2);
    chk("sw_pc", out_pc_a, 32'h104);
    offer_a(1'b1, 32'hFF9F_F06F, 32'h108);
    tick();
    $display("a: jal -> imm=%h fmt=%0d", out_imm_a, out_fmt_a);
    chk("jal_imm", out_imm_a, 32'hFFFF_FFF8);
    chk("jal_fmt", out_fmt_a, 5);
    chk("jal_instr", out_instr_a, 32'hFF9F_F06F);
    offer_a(1'b0, 32'h0, 32'h0);
    tick();
    chk("drain_empty_valid", out_valid_a, 0);

    // ---- XLEN=64 decode stream ----
    step_b(32'h1234_52B7, 64'h1000);
    chk("lui64_imm", out_imm_b, 64'h0000_0000_1234_5000);
    chk("lui64_fmt", out_fmt_b, 4);
    chk("lui64_pc", out_pc_b, 64'h1000);
    step_b(32'h8000_02B7, 64'h1004);
    chk("luineg64_imm", out_imm_b, 64'hFFFF_FFFF_8000_0000);
    step_b(32'h0002_D073, 64'h1008);
    chk("csrrwi_imm", out_imm_b, 64'h5);
    chk("csrrwi_fmt", out_fmt_b, 6);
    chk("csrrwi_ill", out_illegal_b, 0);
    step_b(32'h0000_0000, 64'h100C);
    chk("zero_ill", out_illegal_b, 1);
    chk("zero_fmt", out_fmt_b, 0);
    chk("zero_imm", out_imm_b, 0);
    step_b(32'hFE00_0EE3, 64'h1010);
    chk("beq64_imm", out_imm_b, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq64_fmt", out_fmt_b, 3);
    step_b(32'h7FF0_2083, 64'h1014);
    chk("lw64_imm", out_imm_b, 64'h7FF);
    chk("lw64_fmt", out_fmt_b, 1);
    step_b(32'h3401_1073, 64'h1018);
    chk("csrrw_fmt", out_fmt_b, 0);
    chk("csrrw_ill", out_illegal_b, 0);
    chk("csrrw_imm", out_imm_b, 0);
    step_b(32'h0020_81B3, 64'h101C);
    chk("add_fmt", out_fmt_b, 0);
    chk("add_ill", out_illegal_b, 0);
    step_b(32'h0FF0_000F, 64'h1020);
    chk("fence_ill", out_illegal_b, 0);
    step_b(32'hFFF0_0090, 64'h1024);
    chk("low2_ill", out_illegal_b, 1);
    chk("low2_imm", out_imm_b, 0);
    in_valid_b = 1'b0;

    // ---- backpressure: A, B accepted, C held ----
    out_ready_a = 1'b0;
    offer_a(1'b1, 32'h0050_0093, 32'h200);
    tick();
    chk("bp_a_valid", out_valid_a, 1);
    chk("bp_a_in_ready", in_ready_a, 1);
    offer_a(1'b1, 32'h00A0_0113, 32'h204);
    tick();
    chk("bp_two_in_ready", in_ready_a, 0);
    chk("bp_hold_a", out_instr_a, 32'h0050_0093);
    offer_a(1'b1, 32'h0140_0193, 32'h208);
    tick();
    chk("bp_c_held_in_ready", in_ready_a, 0);
    chk("bp_hold_a2", out_instr_a, 32'h0050_0093);
    chk("bp_hold_imm", out_imm_a, 32'h5);
    out_ready_a = 1'b1;
    tick();
    $display("a: bp out=%h pc=%h", out_instr_a, out_pc_a);
    chk("bp_out_b", out_instr_a, 32'h00A0_0113);
    chk("bp_out_b_pc", out_pc_a, 32'h204);
    chk("bp_ready_back", in_ready_a, 1);
    tick();
    $display("a: bp out=%h pc=%h", out_instr_a, out_pc_a);
    chk("bp_out_c", out_instr_a, 32'h0140_0193);
    chk("bp_out_c_imm", out_imm_a, 32'd20);
    chk("bp_out_c_valid", out_valid_a, 1);
    offer_a(1'b0, 32'h0, 32'h0);
    tick();
    chk("bp_end_valid", out_valid_a, 0);

    // ---- flush while in TWO ----
    out_ready_a = 1'b0;
    offer_a(1'b1, 32'h0010_0093, 32'h300);
    tick();
    offer_a(1'b1, 32'h0020_0093, 32'h304);
    tick();
    chk("fl_two_in_ready", in_ready_a, 0);
    flush_a = 1'b1;
    offer_a(1'b1, 32'h0030_0093, 32'h308);
    tick();
    chk("fl_out_valid", out_valid_a, 0);
    chk("fl_in_ready", in_ready_a, 1);
    flush_a = 1'b0;
    out_ready_a = 1'b1;
    offer_a(1'b1, 32'h0040_0093, 32'h30C);
    tick();
    chk("fl_next_instr", out_instr_a, 32'h0040_0093);
    chk("fl_next_valid", out_valid_a, 1);
    offer_a(1'b0, 32'h0, 32'h0);
    tick();
    chk("fl_next_alone", out_valid_a, 0);

    // ---- flush in ONE with in_ready=1: offered input is dropped ----
    out_ready_a = 1'b0;
    offer_a(1'b1, 32'h0050_0093, 32'h310);
    tick();
    flush_a = 1'b1;
    offer_a(1'b1, 32'h0060_0093, 32'h314);
    chk("fl1_in_ready_before", in_ready_a, 1);
    tick();
    chk("fl1_out_valid", out_valid_a, 0);
    flush_a = 1'b0;
    offer_a(1'b0, 32'h0, 32'h0);
    tick();
    chk("fl1_not_captured", out_valid_a, 0);

    // ---- reset mid-stream in TWO ----
    offer_a(1'b1, 32'h0070_0093, 32'h400);
    tick();
    offer_a(1'b1, 32'h0080_0093, 32'h404);
    tick();
    chk("rs_two_in_ready", in_ready_a, 0);
    rst = 1'b1;
    offer_a(1'b0, 32'h0, 32'h0);
    tick();
    chk("rs_out_valid", out_valid_a, 0);
    chk("rs_in_ready", in_ready_a, 1);
    chk("rs_out_instr", out_instr_a, 32'h0000_0013);
    chk("rs_out_pc", out_pc_a, 0);
    rst = 1'b0;
    out_ready_a = 1'b1;
    tick();
    chk("rs_stays_empty", out_valid_a, 0);
    tick();
    chk("rs_stays_empty2", out_valid_a, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
